pulse_stretcher: RTL and testbench

Converts single-cycle control pulses, such as the one-shot output of the button front end, into fixed-length, human-visible levels for LEDs and LCD status lines. Each accepted pulse produces exactly one high window of `HOLD_CYC` cycles, followed by a mandatory low gap of `GAP_CYC` cycles. Pulses arriving while a window or gap is in progress are queued in a saturating pending counter, so back-to-back presses remain distinguishable. Sits between pulse-producing control logic and slow indicator outputs.

---
 rtl/pulse_stretcher_pkg.sv | 25 ++
 rtl/sat_updown_counter.sv | 38 +++
 rtl/pulse_stretcher.sv | 132 +++++++++++++
 tb/tb_pulse_stretcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding,
// default parameter values and the timer width helper.
package pulse_stretcher_pkg;

    localparam int unsigned DEF_HOLD_CYC = 8;
    localparam int unsigned DEF_GAP_CYC  = 4;
    localparam int unsigned DEF_PEND_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Timer must hold max(hold, gap) - 1; never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned hold,
                                                input int unsigned gap);
        int unsigned m;
        int unsigned w;
        m = (hold > gap) ? hold : gap;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter used to queue pending pulses.
//   clk, rst : clock, async active-low reset
//   inc, dec : count up / down; both together leave the count unchanged
//   count    : registered count, saturates at 2^W-1, floors at 0
//   ovf_c    : combinational, high when an increment is lost to saturation
module sat_updown_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf_c
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic up_only;
    logic dn_only;

    assign up_only = inc && !dec;
    assign dn_only = dec && !inc;

    // A simultaneous inc/dec nets to zero, so it can never overflow.
    assign ovf_c = up_only && (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (up_only && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end else if (dn_only && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into HOLD_CYC-cycle high windows, each
// followed by a GAP_CYC-cycle low gap; pulses arriving mid-window/gap queue.
//   clk, rst : clock, async active-low reset
//   pIN      : single-cycle pulse request
//   clrOvf   : clears the sticky overflow flag
//   lOUT     : stretched level (registered)
//   busy     : state != S_IDLE, decoded from the state register
//   pend     : queued pulses not yet serviced (registered)
//   ovf      : sticky, set when a pulse is lost to a full queue
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
    parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
    parameter int unsigned PEND_W   = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pIN,
    input  logic              clrOvf,
    output logic              lOUT,
    output logic              busy,
    output logic [PEND_W-1:0] pend,
    output logic              ovf
);

    localparam int unsigned TMR_W = timer_width(HOLD_CYC, GAP_CYC);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYC - 1);

    state_t            state;
    state_t            state_n;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_n;
    logic              lout_n;
    logic              pend_inc;
    logic              pend_dec;
    logic              pend_ovf_c;
    logic              timer_done;
    logic              pend_any;

    assign timer_done = (timer == '0);
    assign pend_any   = (pend != '0);
    assign busy       = (state != S_IDLE);

    // Next state, timer reload and queue control.
    always_comb begin
        state_n  = state;
        timer_n  = timer;
        lout_n   = lOUT;
        pend_inc = 1'b0;
        pend_dec = 1'b0;
        case (state)
            S_IDLE: begin
                if (pIN) begin
                    state_n = S_HOLD;
                    timer_n = HOLD_LD;
                    lout_n  = 1'b1;
                end
            end
            S_HOLD: begin
                pend_inc = pIN;
                if (timer_done) begin
                    state_n = S_GAP;
                    timer_n = GAP_LD;
                    lout_n  = 1'b0;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            S_GAP: begin
                if (timer_done) begin
                    if (pend_any || pIN) begin
                        // Queued pulses are served first; a fresh pIN
                        // only bypasses the queue when the queue is empty.
                        pend_dec = pend_any;
                        pend_inc = pIN && pend_any;
                        state_n  = S_HOLD;
                        timer_n  = HOLD_LD;
                        lout_n   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    pend_inc = pIN;
                    timer_n  = timer - TMR_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                timer_n = '0;
                lout_n  = 1'b0;
            end
        endcase
    end

    // State, timer and level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            timer <= '0;
            lOUT  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            lOUT  <= lout_n;
        end
    end

    // Sticky overflow; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (pend_ovf_c) begin
            ovf <= 1'b1;
        end else if (clrOvf) begin
            ovf <= 1'b0;
        end
    end

    sat_updown_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .count (pend),
        .ovf_c (pend_ovf_c)
    );

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random traffic,
// checked every cycle against a remaining-cycles reference model.
module tb_pulse_stretcher;

    localparam int unsigned HOLD = 8;
    localparam int unsigned GAP  = 4;
    localparam int unsigned PW   = 2;
    localparam int unsigned PMAX = (1 << PW) - 1;
    localparam int unsigned PER  = HOLD + GAP;

    logic          clk;
    logic          rst;
    logic          pIN;
    logic          clrOvf;
    logic          lOUT;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;

    int n_tests;
    int n_fail;
    int win_cnt;
    logic prev_l;

    // Model: cycles left in the current window+gap, queued count, ovf.
    int unsigned m_rem;
    int unsigned m_q;
    bit          m_ovf;

    pulse_stretcher #(
        .HOLD_CYC (HOLD),
        .GAP_CYC  (GAP),
        .PEND_W   (PW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pIN    (pIN),
        .clrOvf (clrOvf),
        .lOUT   (lOUT),
        .busy   (busy),
        .pend   (pend),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rem = 0;
        m_q   = 0;
        m_ovf = 0;
    endtask

    task automatic model_edge(input bit p, input bit c);
        bit lost;
        lost = 0;
        if (!rst) begin
            model_reset();
        end else begin
            if (m_rem == 0) begin
                if (p) m_rem = PER;
            end else if (m_rem == 1) begin
                // Last gap cycle: restart from queue or from pIN directly.
                if (m_q > 0) begin
                    m_rem = PER;
                    if (!p) m_q = m_q - 1;
                end else if (p) begin
                    m_rem = PER;
                end else begin
                    m_rem = 0;
                end
            end else begin
                m_rem = m_rem - 1;
                if (p) begin
                    if (m_q == PMAX) lost = 1;
                    else m_q = m_q + 1;
                end
            end
            if (lost) m_ovf = 1;
            else if (c) m_ovf = 0;
        end
    endtask

    task automatic compare_all();
        check("lOUT", 32'(lOUT), 32'(m_rem > GAP));
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("pend", 32'(pend), m_q);
        check("ovf",  32'(ovf),  32'(m_ovf));
    endtask

    // One clock: drive inputs mid-cycle, let the edge happen, compare.
    task automatic cyc(input bit p, input bit c);
        pIN    = p;
        clrOvf = c;
        @(posedge clk);
        model_edge(p, c);
        #1;
        compare_all();
        if (lOUT && !prev_l) win_cnt++;
        prev_l = lOUT;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges, held for n edges.
    task automatic async_reset(input int n);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        idle(n);
        #2;
        rst = 1'b1;
        prev_l = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        win_cnt = 0;
        prev_l  = 1'b0;
        pIN     = 1'b0;
        clrOvf  = 1'b0;
        rst     = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #3;
        rst = 1'b1;
        idle(3);

        // Single pulse: 8 high, 4 low gap, then idle.
        cyc(1'b1, 1'b0);
        for (int i = 1; i < HOLD; i++) cyc(1'b0, 1'b0);
        check("s1_high_end", 32'(lOUT), 32'd1);
        cyc(1'b0, 1'b0);
        check("s1_low", 32'(lOUT), 32'd0);
        idle(GAP - 1);
        check("s1_busy_gap", 32'(busy), 32'd1);
        cyc(1'b0, 1'b0);
        check("s1_busy_end", 32'(busy), 32'd0);
        idle(2);

        // Three spaced pulses: two queue, serviced back to back.
        win_cnt = 0;
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("s2_pend2", 32'(pend), 32'd2);
        idle(3 * PER);
        check("s2_windows", 32'(win_cnt), 32'd3);
        check("s2_idle", 32'(busy), 32'd0);

        // Five consecutive pulses: saturate, overflow, clear.
        win_cnt = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        check("s3_sat", 32'(pend), 32'(PMAX));
        check("s3_ovf", 32'(ovf), 32'd1);
        idle(15);
        cyc(1'b0, 1'b1);
        check("s3_clr", 32'(ovf), 32'd0);
        idle(4 * PER);
        check("s3_windows", 32'(win_cnt), 32'd4);

        // pIN on the final gap cycle with an empty queue.
        cyc(1'b1, 1'b0);
        idle(PER - 1);
        cyc(1'b1, 1'b0);
        check("s4_restart", 32'(lOUT), 32'd1);
        check("s4_pend0", 32'(pend), 32'd0);
        idle(PER + 2);

        // Same, with one pulse already queued.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        idle(PER - 2);
        cyc(1'b1, 1'b0);
        check("s4_pend1", 32'(pend), 32'd1);
        idle(2 * PER + 2);

        // Reset mid-window drops everything; no window afterwards.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        idle(2);
        async_reset(2);
        idle(PER);
        check("s5_quiet", 32'(busy), 32'd0);

        // Overflow and clear in the same cycle: set wins.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        check("s6_cleared", 32'(ovf), 32'd0);
        cyc(1'b1, 1'b1);
        check("s6_set_prio", 32'(ovf), 32'd1);
        idle(5 * PER);

        // Random traffic with varying density, clears and resets.
        begin
            int dens;
            dens = 20;
            for (int i = 0; i < 2400; i++) begin
                if (i % 200 == 0) dens = $urandom_range(5, 90);
                cyc(bit'($urandom_range(0, 99) < dens),
                    bit'($urandom_range(0, 15) == 0));
                if ($urandom_range(0, 399) == 0) async_reset(1);
            end
        end
        idle(8 * PER);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
